// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline.
// Adds multi-cycle load and iterative mul/div stalls plus saturating perf counters.
module hazard_ctrl_mc #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              LoadM,
    input  logic              PCSrcE,
    input  logic              MdStartE,
    input  logic              MdDoneE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {RUN, LD_WAIT, MD_BUSY} state_t;

    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam bit LD_EN = (LOAD_LAT > 0);
    localparam logic [CW-1:0] CNT_INIT = LD_EN ? CW'(LOAD_LAT - 1) : '0;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ld_enter;
    logic          ld_wait;
    logic          md_stall;
    logic          load_use;
    logic          br_flush;

    assign ld_enter = LD_EN && (state == RUN) && LoadM;
    assign ld_wait  = (state == LD_WAIT);
    // A load entering LD_WAIT wins; the mul/div start is picked up again afterwards.
    assign md_stall = ((state == MD_BUSY) ||
                       ((state == RUN) && MdStartE && !ld_enter)) && !MdDoneE;
    assign load_use = (state == RUN) && ResultSrcE && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        FlushW   = 1'b0;
        br_flush = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            priority case (1'b1)
                ld_wait: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end
                md_stall: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
                PCSrcE: begin
                    FlushD   = 1'b1;
                    FlushE   = 1'b1;
                    br_flush = 1'b1;
                end
                load_use: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (Rs1E != '0 && RegWriteM && RdM == Rs1E)      ForwardAE = 2'b10;
            else if (Rs1E != '0 && RegWriteW && RdW == Rs1E) ForwardAE = 2'b01;
            if (Rs2E != '0 && RegWriteM && RdM == Rs2E)      ForwardBE = 2'b10;
            else if (Rs2E != '0 && RegWriteW && RdW == Rs2E) ForwardBE = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_enter) begin
                        state <= LD_WAIT;
                        cnt   <= CNT_INIT;
                    end else if (MdStartE && !MdDoneE) begin
                        state <= MD_BUSY;
                    end
                end
                LD_WAIT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                MD_BUSY: begin
                    if (MdDoneE) state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (br_flush && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: two instances (LOAD_LAT=2/CNT_W=32
// and LOAD_LAT=0/CNT_W=4) share one stimulus.
module tb_hazard_ctrl_mc;

    logic clk, rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, ResultSrcE, LoadM, PCSrcE, MdStartE, MdDoneE;

    logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw;
    logic [1:0] a_fa, a_fb;
    logic [31:0] a_sc, a_fc;
    logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw;
    logic [1:0] b_fa, b_fb;
    logic [3:0] b_sc, b_fc;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_mc #(.ADDR_W(5), .LOAD_LAT(2), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .LoadM(LoadM), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
        .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .FlushW(a_fw),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .stall_cycles(a_sc), .flush_count(a_fc)
    );

    hazard_ctrl_mc #(.ADDR_W(5), .LOAD_LAT(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .LoadM(LoadM), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
        .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .FlushW(b_fw),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .stall_cycles(b_sc), .flush_count(b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; LoadM = 0;
        PCSrcE = 0; MdStartE = 0; MdDoneE = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1;
        RdM = 7; Rs1E = 7; RegWriteM = 1; MdStartE = 1; LoadM = 1;
        tick();
        checks++;
        if ({a_fd, a_fe, a_sf, a_sd, a_se, a_sm, a_fm, a_fw} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 11000000",
                     {a_fd, a_fe, a_sf, a_sd, a_se, a_sm, a_fm, a_fw});
        end
        checks++;
        if (a_fa !== 2'b00) begin
            errors++;
            $display("FAIL reset_fwd: got %b expected 00", a_fa);
        end
        checks++;
        if (a_sc !== 32'd0 || a_fc !== 32'd0 || b_sc !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", a_sc, a_fc, b_sc);
        end
        rst = 0;
        clr_in();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 1; RdE = 5; Rs1D = 5; Rs2D = 1;
        #1;
        checks++;
        if ({b_sf, b_sd, b_fe, b_se} !== 4'b1110) begin
            errors++;
            $display("FAIL lu_stall: got %b expected 1110", {b_sf, b_sd, b_fe, b_se});
        end
        tick();
        clr_in();
        RdM = 5; RegWriteM = 1;
        #1;
        checks++;
        if ({b_sf, b_fe} !== 2'b00) begin
            errors++;
            $display("FAIL lu_release: got %b expected 00", {b_sf, b_fe});
        end
        tick();
        clr_in();
        Rs1E = 5; Rs2E = 1; RdW = 5; RegWriteW = 1;
        #1;
        checks++;
        if (b_fa !== 2'b01 || b_fb !== 2'b00) begin
            errors++;
            $display("FAIL lu_fwd: got %b/%b expected 01/00", b_fa, b_fb);
        end
        checks++;
        if (b_sc !== 4'd1) begin
            errors++;
            $display("FAIL lu_cnt: got %0d expected 1", b_sc);
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        LoadM = 1;
        #1;
        checks++;
        if (a_sf !== 1'b0) begin
            errors++;
            $display("FAIL ld_first: got %b expected 0", a_sf);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            LoadM = 0;
            #1;
            checks++;
            if ({a_sf, a_sd, a_se, a_sm, a_fw, a_fm} !== 6'b111110) begin
                errors++;
                $display("FAIL ld_wait%0d: got %b expected 111110", i,
                         {a_sf, a_sd, a_se, a_sm, a_fw, a_fm});
            end
            checks++;
            if (b_sm !== 1'b0) begin
                errors++;
                $display("FAIL ld_lat0: got %b expected 0", b_sm);
            end
        end
        tick();
        #1;
        checks++;
        if ({a_sf, a_sd, a_se, a_sm, a_fw} !== 5'b00000) begin
            errors++;
            $display("FAIL ld_done: got %b expected 00000", {a_sf, a_sd, a_se, a_sm, a_fw});
        end
        checks++;
        if (a_sc !== 32'd2) begin
            errors++;
            $display("FAIL ld_cnt: got %0d expected 2", a_sc);
        end
    endtask

    task automatic test_muldiv();
        do_reset();
        MdStartE = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({a_sf, a_sd, a_se, a_fm, a_sm} !== 5'b11110) begin
                errors++;
                $display("FAIL md_busy%0d: got %b expected 11110", i,
                         {a_sf, a_sd, a_se, a_fm, a_sm});
            end
            tick();
        end
        MdDoneE = 1;
        #1;
        checks++;
        if ({a_sf, a_sd, a_se, a_fm} !== 4'b0000) begin
            errors++;
            $display("FAIL md_done: got %b expected 0000", {a_sf, a_sd, a_se, a_fm});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (a_sc !== 32'd5 || a_se !== 1'b0) begin
            errors++;
            $display("FAIL md_cnt: got %0d/%b expected 5/0", a_sc, a_se);
        end
        MdStartE = 1; MdDoneE = 1;
        #1;
        checks++;
        if ({a_sf, a_se, a_fm} !== 3'b000) begin
            errors++;
            $display("FAIL md_instant: got %b expected 000", {a_sf, a_se, a_fm});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if ({a_sf, a_se, a_fm} !== 3'b000) begin
            errors++;
            $display("FAIL md_instant_next: got %b expected 000", {a_sf, a_se, a_fm});
        end
    endtask

    task automatic test_branch();
        do_reset();
        ResultSrcE = 1; RdE = 5; Rs1D = 5; PCSrcE = 1;
        #1;
        checks++;
        if ({a_fd, a_fe, a_sf, a_sd} !== 4'b1100) begin
            errors++;
            $display("FAIL br_cancel_lu: got %b expected 1100", {a_fd, a_fe, a_sf, a_sd});
        end
        tick();
        clr_in();
        LoadM = 1;
        #1;
        checks++;
        if (a_fc !== 32'd1 || a_sc !== 32'd0) begin
            errors++;
            $display("FAIL br_cnt: got %0d/%0d expected 1/0", a_fc, a_sc);
        end
        tick();
        LoadM = 0; PCSrcE = 1;
        #1;
        checks++;
        if ({a_fd, a_fe} !== 2'b00) begin
            errors++;
            $display("FAIL br_held: got %b expected 00", {a_fd, a_fe});
        end
        tick();
        tick();
        #1;
        checks++;
        if ({a_fd, a_fe, a_se} !== 3'b110) begin
            errors++;
            $display("FAIL br_release: got %b expected 110", {a_fd, a_fe, a_se});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (a_fc !== 32'd2) begin
            errors++;
            $display("FAIL br_cnt2: got %0d expected 2", a_fc);
        end
    endtask

    task automatic test_forward();
        do_reset();
        RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1;
        #1;
        checks++;
        if (a_fa !== 2'b10 || a_fb !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_prio: got %b/%b expected 10/10", a_fa, a_fb);
        end
        RegWriteM = 0;
        #1;
        checks++;
        if (a_fa !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w: got %b expected 01", a_fa);
        end
        RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 3;
        #1;
        checks++;
        if (a_fa !== 2'b00 || a_fb !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0: got %b/%b expected 00/00", a_fa, a_fb);
        end
        clr_in();
    endtask

    task automatic test_saturate();
        do_reset();
        ResultSrcE = 1; RdE = 9; Rs2D = 9;
        for (int i = 0; i < 20; i++) tick();
        clr_in();
        #1;
        checks++;
        if (b_sc !== 4'hF) begin
            errors++;
            $display("FAIL sat_cnt: got %0h expected f", b_sc);
        end
        checks++;
        if (a_sc !== 32'd20) begin
            errors++;
            $display("FAIL wide_cnt: got %0d expected 20", a_sc);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        MdStartE = 1;
        tick();
        tick();
        rst = 1; MdStartE = 0;
        #1;
        checks++;
        if ({a_sf, a_se, a_fm, a_fd, a_fe} !== 5'b00011) begin
            errors++;
            $display("FAIL rst_md_during: got %b expected 00011", {a_sf, a_se, a_fm, a_fd, a_fe});
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if ({a_sf, a_sd, a_se, a_sm, a_fm} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_md_after: got %b expected 00000", {a_sf, a_sd, a_se, a_sm, a_fm});
        end
        LoadM = 1;
        tick();
        LoadM = 0;
        #1;
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if ({a_sf, a_sm, a_fw} !== 3'b000) begin
            errors++;
            $display("FAIL rst_ld_after: got %b expected 000", {a_sf, a_sm, a_fw});
        end
    endtask

    task automatic test_ld_md_same();
        do_reset();
        LoadM = 1; MdStartE = 1;
        #1;
        checks++;
        if (a_fm !== 1'b0) begin
            errors++;
            $display("FAIL same_nofm: got %b expected 0", a_fm);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            LoadM = 0;
            #1;
            checks++;
            if ({a_sm, a_fw, a_fm} !== 3'b110) begin
                errors++;
                $display("FAIL same_ldwait%0d: got %b expected 110", i, {a_sm, a_fw, a_fm});
            end
        end
        tick();
        #1;
        checks++;
        if ({a_se, a_sm, a_fm} !== 3'b101) begin
            errors++;
            $display("FAIL same_md_resample: got %b expected 101", {a_se, a_sm, a_fm});
        end
        MdDoneE = 1;
        #1;
        checks++;
        if ({a_se, a_fm} !== 2'b00) begin
            errors++;
            $display("FAIL same_md_done: got %b expected 00", {a_se, a_fm});
        end
        tick();
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1;
        test_reset();
        test_load_use();
        test_load_wait();
        test_muldiv();
        test_branch();
        test_forward();
        test_saturate();
        test_rst_mid();
        test_ld_md_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
